// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the display path (add/sub/ALUOut) among three requesters.
// Each grant is held for at least HOLD cycles; all outputs come straight from flops.
module disp_arbiter #(
  parameter int unsigned HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] req,
  input  logic [7:0] val0,
  input  logic [7:0] val1,
  input  logic [7:0] val2,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [1:0] op2,
  output logic [2:0] grant,
  output logic       add,
  output logic       sub,
  output logic [7:0] ALUOut,
  output logic       busy
);

  localparam logic [7:0] HoldCnt = 8'(HOLD);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load;

  logic [2:0] grant_q, grant_d;
  logic       add_q, add_d;
  logic       sub_q, sub_d;
  logic [7:0] aluout_q, aluout_d;
  logic       busy_q, busy_d;

  logic [2:0] owner_oh;
  logic [2:0] others;
  logic       dwell_done;

  // First set bit in order p+1, p+2, p+3 (mod 3); callers guarantee r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] win;
    logic [1:0] idx;
    win = p;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(p) + k) % 3);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign owner_oh   = to_onehot(owner_q);
  assign others     = req & ~owner_oh;
  assign dwell_done = (cnt_q >= HoldCnt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      owner_q  <= 2'd0;
      ptr_q    <= 2'd2;
      cnt_q    <= 8'd0;
      grant_q  <= 3'b000;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      aluout_q <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      add_q    <= add_d;
      sub_q    <= sub_d;
      aluout_q <= aluout_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StOwn;
          owner_d = rr_pick(req, ptr_q);
          ptr_d   = owner_d;
          cnt_d   = 8'd1;
          load    = 1'b1;
        end
      end
      StOwn: begin
        if (dwell_done && |others) begin
          // ptr_q equals the owner here, so masking it out skips the owner.
          owner_d = rr_pick(others, ptr_q);
          ptr_d   = owner_d;
          cnt_d   = 8'd1;
          load    = 1'b1;
        end else if (dwell_done && !req[owner_q]) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = (cnt_q < HoldCnt) ? cnt_q + 8'd1 : cnt_q;
          load  = req[owner_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic [1:0] sel_op;
    logic [7:0] sel_val;
    case (owner_d)
      2'd1:    begin sel_op = op1; sel_val = val1; end
      2'd2:    begin sel_op = op2; sel_val = val2; end
      default: begin sel_op = op0; sel_val = val0; end
    endcase

    grant_d  = 3'b000;
    busy_d   = 1'b0;
    add_d    = add_q;
    sub_d    = sub_q;
    aluout_d = aluout_q;
    if (state_d == StIdle) begin
      // ALUOut keeps the last shown value while idle.
      add_d = 1'b0;
      sub_d = 1'b0;
    end else begin
      grant_d = to_onehot(owner_d);
      busy_d  = 1'b1;
      if (load) begin
        add_d    = (sel_op == 2'b01);
        sub_d    = (sel_op == 2'b10);
        aluout_d = sel_val;
      end
    end
  end

  assign grant  = grant_q;
  assign add    = add_q;
  assign sub    = sub_q;
  assign ALUOut = aluout_q;
  assign busy   = busy_q;

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-shares the minicomputer's single display path (the `add`/`sub` flags and the 8-bit `ALUOut` value consumed by the seven-segment/LED display driver) among three requesters: ALU result, register-file peek and program counter. Round-robin arbitration with a minimum dwell time keeps each granted value on the display long enough to read. All outputs are registered and feed the display driver directly.

## Interface
- HOLD, default 8: minimum cycles a grant is held. Legal range 1..255.
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  3  per-requester request, level; bit i belongs to requester i.
- val0, val1, val2  in  8 each  value to display for requesters 0, 1, 2.
- op0, op1, op2  in  2 each  flag selector for requesters 0, 1, 2: 01 = add, 10 = sub, 00/11 = neither.
- grant  out  3  one-hot current owner; 000 when idle.
- add  out  1  to display driver.
- sub  out  1  to display driver.
- ALUOut  out  8  to display driver.
- busy  out  1  high while any grant is active (equals |grant).

## Operation
- Reset values: grant=000, add=0, sub=0, ALUOut=00, busy=0, state IDLE, dwell counter 0, round-robin pointer=2, so requester 0 has first priority.
- States:
  - IDLE: no owner.
  - OWN: exactly one grant bit set.
- Round-robin search order from pointer p is p+1, p+2, p+3 (mod 3). The first set req bit wins. The pointer updates to the winner at each grant.
- IDLE to OWN: at the edge where any req is sampled high.
  - grant is set to the winner and the dwell counter to 1.
  - add/sub/ALUOut are loaded from the winner's op/val at that same edge.
- While in OWN, at each edge:
  - If req[owner]=1: reload add/sub/ALUOut from the owner's inputs.
  - Else: hold them.
  - Counter increments, saturating at HOLD.
- Release check, evaluated at each edge in OWN where counter ≥ HOLD:
  - Another req pending: switch directly to the next round-robin winner, skipping the current owner. There is no idle cycle between owners. Counter=1, outputs load from the new owner.
  - Else if req[owner]=0: go to IDLE. grant=000, add=0, sub=0, ALUOut holds its last value.
  - Else (owner still requesting, nobody else): stay in OWN.
- The owner dropping req before HOLD does not end the grant early. The display keeps the frozen value until dwell expires.
- Flag decode: add=(op==01), sub=(op==10). add and sub are never both 1.
- RST high at any edge, including mid-grant, forces the full reset state at that edge. RST has priority over all other conditions.

## Timing
- Latency: req high sampled at edge n in IDLE produces grant and outputs valid after edge n (one cycle). Combinational paths from inputs to outputs are forbidden.
- Minimum grant length is HOLD cycles. With HOLD=1, a contested grant rotates every cycle.
- Owner-to-owner handover happens at a single edge. Old and new grant bits are never simultaneously set.
- Simultaneous requests in IDLE resolve purely by pointer. Requests arriving mid-grant wait; they are not queued beyond their level.
- Counter width is 8 bits and saturates. It never wraps.

## Test plan
- Reset then single request, HOLD=8:
  - RST for 2 cycles: all outputs 0.
  - req=001, val0=14, op0=01: one cycle later grant=001, add=1, sub=0, ALUOut=14, busy=1.
  - Drop req at cycle 3: outputs hold 14 until the dwell count reaches 8, then grant=000, add=0, ALUOut stays 14.
- Round robin: hold req=111 continuously.
  - Grants go 001, 010, 100, 001…, each lasting exactly 8 cycles with no idle gap.
  - ALUOut tracks val0=1E, val1=1F, val2=20 in turn.
- Live tracking: sole owner req0 held high while val0 steps 14→1D once per 8 cycles. ALUOut follows one cycle behind with no release.
- Sub flag and illegal op:
  - op1=10: sub=1, add=0.
  - op1=11: add=0, sub=0, value still shown.
- Mid-grant reset: pulse RST at cycle 4 of a req2 grant. The next edge gives grant=000, ALUOut=00. A following simultaneous req=110 grants requester 1 first, since the pointer was reset to 2.
- HOLD=1 rebuild: req=011 continuous alternates grant 001/010 every cycle.
